platform_collision_scanner: RTL and testbench
=============================================

Name: platform_collision_scanner

Overview:
Sequential, parametrised collision engine for player and AI sprites. It holds a writable table of N_PLAT platforms. On a start request it clamps the object to the screen, then scans the table at one platform per clock. It reports a per-direction collision summary, the first hitting platform index and a hit count. The block replaces the wide combinational all-platform OR in the move/jump controllers and frees timing at 65 MHz.

Parameters:
N_PLAT, 19, number of platform table entries (≥2)
COORD_W, 11, coordinate/length width in bits
SCREEN_W, 1024, horizontal screen size in pixels
SCREEN_H, 768, vertical screen size in pixels
IDX_W (localparam), $clog2(N_PLAT), table index width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
plat_we  in  1  table write strobe
plat_idx  in  IDX_W  table write index
plat_x  in  COORD_W  platform left x
plat_y  in  COORD_W  platform collision y
plat_len  in  COORD_W  platform length
plat_en  in  1  entry enable
wr_err  out  1  one-cycle pulse: rejected write
start  in  1  scan request
obj_x, obj_y  in  COORD_W  object upper-left corner
obj_w, obj_h  in  COORD_W  object width / height
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle result-valid pulse
x_clamped, y_clamped  out  COORD_W  corrected coordinates
coll  out  2  OR-ed legacy code: 11 side, 10 top, 01 bottom, 00 none
hit_side, hit_top, hit_bottom  out  1  per-direction sticky flags
first_idx  out  IDX_W  lowest index that hit (0 if none)
hit_count  out  IDX_W+1  number of entries that hit

Behaviour:
- Reset: all outputs 0; table entries cleared (plat_en = 0); FSM enters IDLE. Reset asserted mid-scan aborts the scan and no done pulse is issued.
- FSM states:
  - IDLE: start=1 latches obj_* and sets busy; next state CLAMP.
  - CLAMP: one cycle; registers x_clamped/y_clamped; clears flags, count and first_idx; loads scan index 0; next state SCAN.
  - SCAN: evaluates entry[idx] each cycle; after idx = N_PLAT-1, next state DONE.
  - DONE: done=1 for one cycle; busy drops with done; next state IDLE.
- Latency: done is high exactly N_PLAT+2 cycles after the start-sampling edge. All result outputs hold stable from done until the next accepted start.
- start is ignored while busy, with no queueing.
- Table writes:
  - Accepted in IDLE only. Data is visible to the next scan.
  - plat_we while busy, or plat_idx ≥ N_PLAT, is ignored and pulses wr_err for one cycle.
  - A write and a start in the same IDLE cycle: the write lands first and the scan sees it.
- Clamp (applied independently per axis, X shown; Y uses SCREEN_H, obj_h):
  - x < 1 → 1
  - else if x+w > SCREEN_W-1 → SCREEN_W-1-w
  - else → x
  - If w ≥ SCREEN_W-2, the result is 1.
- Arithmetic: all sums use COORD_W+1 bits, with no wrap. Scanning uses the clamped coordinates.
- Per-entry test (disabled entries never hit). Priority is side > top > bottom, giving one code per entry:
  - side: (x == xs+len or x+w == xs) and y+h ≥ yp and y ≤ yp
  - top: y+h == yp and x+w ≥ xs and x ≤ xs+len
  - bottom: y == yp and x+w ≥ xs and x ≤ xs+len
- Accumulation:
  - The matching flag is set and hit_count is incremented.
  - first_idx is captured on the first hit only.
  - coll = {hit_side|hit_top, hit_side|hit_bottom}.

Decomposition:
- game_pkg gains a plat_entry_t packed struct {en, x, y, len} and a scan_state_t enum {IDLE, CLAMP, SCAN, DONE}.
- Default platform constants P1..P19 stay in game_pkg. A top-level loader writes them after reset.
- One combinational sub-module, plat_hit_eval, takes one entry plus the object and returns a 2-bit code. The scanner instantiates one copy.

Test Plan:
1. Entry 0 = {1,100,500,200}; obj (150,440,40,60) → done at cycle 21; coll=10, hit_top=1, first_idx=0, hit_count=1.
2. Same table; obj (60,470,40,60), so x+w=100 → coll=11, hit_side=1, hit_top=0.
3. Entry 0 as in 1, entry 5 = {1,150,440,50}; obj (150,440,40,60) → hit_top=1, hit_bottom=1, coll=11, first_idx=0, hit_count=2.
4. Clamp: obj (0,900,40,60) → x_clamped=1, y_clamped=707, no hits with an empty table.
5. Handshake: start again at cycle 5 of a scan → ignored, a single done. plat_we during busy → wr_err pulse and the table is unchanged. plat_idx=19 in IDLE → wr_err.
6. Assert rst at cycle 10 of a scan → all outputs 0 and busy=0; no done pulse ever appears; a fresh start then completes normally with an empty table (coll=00).

Source files
------------

// File: rtl/platform_collision_scanner_pkg.sv
// platform_collision_scanner_pkg: shared types and default platform layout for the collision scanner
package platform_collision_scanner_pkg;

    localparam int GAME_COORD_W = 11;

    typedef enum logic [1:0] {IDLE, CLAMP, SCAN, DONE} scan_state_t;

    typedef struct packed {
        logic                    en;
        logic [GAME_COORD_W-1:0] x;
        logic [GAME_COORD_W-1:0] y;
        logic [GAME_COORD_W-1:0] len;
    } plat_entry_t;

    localparam plat_entry_t P1  = '{1'b1, 11'd0,   11'd740, 11'd1023};
    localparam plat_entry_t P2  = '{1'b1, 11'd100, 11'd660, 11'd180};
    localparam plat_entry_t P3  = '{1'b1, 11'd400, 11'd660, 11'd160};
    localparam plat_entry_t P4  = '{1'b1, 11'd700, 11'd660, 11'd200};
    localparam plat_entry_t P5  = '{1'b1, 11'd40,  11'd580, 11'd120};
    localparam plat_entry_t P6  = '{1'b1, 11'd260, 11'd580, 11'd140};
    localparam plat_entry_t P7  = '{1'b1, 11'd520, 11'd580, 11'd140};
    localparam plat_entry_t P8  = '{1'b1, 11'd800, 11'd580, 11'd160};
    localparam plat_entry_t P9  = '{1'b1, 11'd150, 11'd500, 11'd200};
    localparam plat_entry_t P10 = '{1'b1, 11'd600, 11'd500, 11'd220};
    localparam plat_entry_t P11 = '{1'b1, 11'd0,   11'd420, 11'd140};
    localparam plat_entry_t P12 = '{1'b1, 11'd380, 11'd420, 11'd180};
    localparam plat_entry_t P13 = '{1'b1, 11'd860, 11'd420, 11'd163};
    localparam plat_entry_t P14 = '{1'b1, 11'd200, 11'd340, 11'd120};
    localparam plat_entry_t P15 = '{1'b1, 11'd640, 11'd340, 11'd140};
    localparam plat_entry_t P16 = '{1'b1, 11'd60,  11'd260, 11'd160};
    localparam plat_entry_t P17 = '{1'b1, 11'd420, 11'd260, 11'd200};
    localparam plat_entry_t P18 = '{1'b1, 11'd780, 11'd260, 11'd180};
    localparam plat_entry_t P19 = '{1'b1, 11'd300, 11'd180, 11'd400};

endpackage

// File: rtl/platform_collision_scanner_hit_eval.sv
// plat_hit_eval: classifies one platform entry against the object as side/top/bottom/none
module plat_hit_eval #(
    parameter int COORD_W = 11
) (
    input  logic               en,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] plen,
    input  logic [COORD_W-1:0] ox,
    input  logic [COORD_W-1:0] oy,
    input  logic [COORD_W-1:0] ow,
    input  logic [COORD_W-1:0] oh,
    output logic [1:0]         code
);
    logic [COORD_W:0] p_r, o_r, o_b, px_e, py_e, ox_e;
    logic side, top, bot;

    assign px_e = {1'b0, px};
    assign py_e = {1'b0, py};
    assign ox_e = {1'b0, ox};
    assign p_r  = px_e + {1'b0, plen};
    assign o_r  = ox_e + {1'b0, ow};
    assign o_b  = {1'b0, oy} + {1'b0, oh};

    // side beats top beats bottom so each entry yields a single code
    always_comb begin
        side = (ox_e == p_r || o_r == px_e) && o_b >= py_e && oy <= py;
        top  = o_b == py_e && o_r >= px_e && ox_e <= p_r;
        bot  = oy == py && o_r >= px_e && ox_e <= p_r;
        code = !en ? 2'b00 : side ? 2'b11 : top ? 2'b10 : bot ? 2'b01 : 2'b00;
    end
endmodule

// File: rtl/platform_collision_scanner.sv
// platform_collision_scanner: clamps an object to the screen then scans the platform table one entry per clock
module platform_collision_scanner
    import platform_collision_scanner_pkg::*;
#(
    parameter int N_PLAT   = 19,
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    localparam int IDX_W   = $clog2(N_PLAT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               plat_we,
    input  logic [IDX_W-1:0]   plat_idx,
    input  logic [COORD_W-1:0] plat_x,
    input  logic [COORD_W-1:0] plat_y,
    input  logic [COORD_W-1:0] plat_len,
    input  logic               plat_en,
    output logic               wr_err,
    input  logic               start,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_w,
    input  logic [COORD_W-1:0] obj_h,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] x_clamped,
    output logic [COORD_W-1:0] y_clamped,
    output logic [1:0]         coll,
    output logic               hit_side,
    output logic               hit_top,
    output logic               hit_bottom,
    output logic [IDX_W-1:0]   first_idx,
    output logic [IDX_W:0]     hit_count
);
    localparam int S = COORD_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PLAT - 1);

    scan_state_t state, nxt;
    logic               t_en  [N_PLAT];
    logic [COORD_W-1:0] t_x   [N_PLAT];
    logic [COORD_W-1:0] t_y   [N_PLAT];
    logic [COORD_W-1:0] t_len [N_PLAT];
    logic [COORD_W-1:0] ox, oy, ow, oh;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         code;
    logic               idx_ok, wr_ok;

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] d,
                                                 input int lim);
        logic [S-1:0] sum;
        sum = {1'b0, v} + {1'b0, d};
        return ({1'b0, d} >= S'(lim - 2) || v == '0) ? COORD_W'(1)
             : sum > S'(lim - 1) ? COORD_W'(lim - 1) - d : v;
    endfunction

    assign idx_ok = {1'b0, plat_idx} < (IDX_W + 1)'(N_PLAT);
    assign wr_ok  = plat_we && state == IDLE && idx_ok;
    assign coll   = {hit_side | hit_top, hit_side | hit_bottom};

    plat_hit_eval #(.COORD_W(COORD_W)) u_eval (
        .en   (t_en[idx]),
        .px   (t_x[idx]),
        .py   (t_y[idx]),
        .plen (t_len[idx]),
        .ox   (x_clamped),
        .oy   (y_clamped),
        .ow   (ow),
        .oh   (oh),
        .code (code)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // IDLE -> CLAMP -> SCAN (N_PLAT cycles) -> DONE -> IDLE
    always_comb begin
        nxt = state == IDLE  ? (start ? CLAMP : IDLE)
            : state == CLAMP ? SCAN
            : state == SCAN  ? (idx == LAST ? DONE : SCAN)
            : IDLE;
    end

    // platform table; writes only land while idle so a scan always sees a frozen table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PLAT; i++) begin
                t_en[i]  <= 1'b0;
                t_x[i]   <= '0;
                t_y[i]   <= '0;
                t_len[i] <= '0;
            end
        end else if (wr_ok) begin
            t_en[plat_idx]  <= plat_en;
            t_x[plat_idx]   <= plat_x;
            t_y[plat_idx]   <= plat_y;
            t_len[plat_idx] <= plat_len;
        end
    end

    // object latch, clamp, per-entry accumulation and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ox, oy, ow, oh} <= '0;
            {x_clamped, y_clamped} <= '0;
            {hit_side, hit_top, hit_bottom} <= '0;
            first_idx <= '0;
            hit_count <= '0;
            idx <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            done <= 1'b0;
            wr_err <= plat_we && !wr_ok;
            case (state)
                IDLE: if (start) begin
                    {ox, oy, ow, oh} <= {obj_x, obj_y, obj_w, obj_h};
                    busy <= 1'b1;
                end
                CLAMP: begin
                    x_clamped <= clamp(ox, ow, SCREEN_W);
                    y_clamped <= clamp(oy, oh, SCREEN_H);
                    {hit_side, hit_top, hit_bottom} <= '0;
                    first_idx <= '0;
                    hit_count <= '0;
                    idx <= '0;
                end
                SCAN: begin
                    if (code != 2'b00) begin
                        hit_side   <= hit_side   | (code == 2'b11);
                        hit_top    <= hit_top    | (code == 2'b10);
                        hit_bottom <= hit_bottom | (code == 2'b01);
                        hit_count  <= hit_count + 1'b1;
                        if (hit_count == '0) first_idx <= idx;
                    end
                    idx <= idx == LAST ? idx : idx + 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_platform_collision_scanner.sv
// tb_platform_collision_scanner: directed plus randomized checks against a behavioural scanner model
module tb_platform_collision_scanner;
    localparam int N = 19;
    localparam int CW = 11;
    localparam int IW = $clog2(N);

    logic clk = 1'b0, rst = 1'b1;
    logic plat_we = 1'b0, plat_en = 1'b0, start = 1'b0;
    logic [IW-1:0] plat_idx = '0;
    logic [CW-1:0] plat_x = '0, plat_y = '0, plat_len = '0;
    logic [CW-1:0] obj_x = '0, obj_y = '0, obj_w = '0, obj_h = '0;
    logic wr_err, busy, done, hit_side, hit_top, hit_bottom;
    logic [CW-1:0] x_clamped, y_clamped;
    logic [1:0] coll;
    logic [IW-1:0] first_idx;
    logic [IW:0] hit_count;

    int checks = 0, fails = 0, n_done = 0;
    int m_en [N], m_x [N], m_y [N], m_len [N];
    int m_busy = 0, m_cnt = 0, m_done = 0, m_wr_err = 0;
    int ox = 0, oy = 0, ow = 0, oh = 0;
    int e_xc = 0, e_yc = 0, e_side = 0, e_top = 0, e_bot = 0, e_first = 0, e_cnt = 0;

    always #5 clk = ~clk;

    platform_collision_scanner dut (
        .clk(clk), .rst(rst), .plat_we(plat_we), .plat_idx(plat_idx), .plat_x(plat_x),
        .plat_y(plat_y), .plat_len(plat_len), .plat_en(plat_en), .wr_err(wr_err),
        .start(start), .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .busy(busy), .done(done), .x_clamped(x_clamped), .y_clamped(y_clamped),
        .coll(coll), .hit_side(hit_side), .hit_top(hit_top), .hit_bottom(hit_bottom),
        .first_idx(first_idx), .hit_count(hit_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampf(input int v, input int d, input int lim);
        if (d >= lim - 2) return 1;
        if (v < 1) return 1;
        if (v + d > lim - 1) return lim - 1 - d;
        return v;
    endfunction

    function automatic int hitcode(input int en, input int xs, input int yp, input int len,
                                   input int x, input int y, input int w, input int h);
        if (en == 0) return 0;
        if ((x == xs + len || x + w == xs) && y + h >= yp && y <= yp) return 3;
        if (y + h == yp && x + w >= xs && x <= xs + len) return 2;
        if (y == yp && x + w >= xs && x <= xs + len) return 1;
        return 0;
    endfunction

    // reference model: cycle-level handshake, table contents and scan result
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_len[i] = 0;
            end
            m_busy = 0; m_cnt = 0; m_done = 0; m_wr_err = 0;
            e_xc = 0; e_yc = 0; e_side = 0; e_top = 0; e_bot = 0; e_first = 0; e_cnt = 0;
        end else begin
            m_wr_err = (plat_we && (m_busy != 0 || int'(plat_idx) >= N)) ? 1 : 0;
            m_done = 0;
            if (plat_we && m_busy == 0 && int'(plat_idx) < N) begin
                m_en[plat_idx] = int'(plat_en); m_x[plat_idx] = int'(plat_x);
                m_y[plat_idx] = int'(plat_y); m_len[plat_idx] = int'(plat_len);
            end
            if (m_busy != 0) begin
                m_cnt++;
                if (m_cnt == N + 2) begin
                    m_busy = 0; m_done = 1;
                    e_xc = clampf(ox, ow, 1024); e_yc = clampf(oy, oh, 768);
                    e_side = 0; e_top = 0; e_bot = 0; e_first = 0; e_cnt = 0;
                    for (int i = 0; i < N; i++) begin
                        int c;
                        c = hitcode(m_en[i], m_x[i], m_y[i], m_len[i], e_xc, e_yc, ow, oh);
                        if (c != 0) begin
                            if (e_cnt == 0) e_first = i;
                            e_cnt++;
                            if (c == 3) e_side = 1; else if (c == 2) e_top = 1; else e_bot = 1;
                        end
                    end
                end
            end else if (start) begin
                m_busy = 1; m_cnt = 0;
                ox = int'(obj_x); oy = int'(obj_y); ow = int'(obj_w); oh = int'(obj_h);
            end
        end
    end

    // every cycle: handshake always, results whenever they are defined to be stable
    always @(posedge clk) begin
        #1;
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
        chk("wr_err", int'(wr_err), m_wr_err);
        if (done) n_done++;
        if (m_busy == 0) begin
            chk("x_clamped", int'(x_clamped), e_xc);
            chk("y_clamped", int'(y_clamped), e_yc);
            chk("coll", int'(coll), (e_side | e_top) * 2 + (e_side | e_bot));
            chk("hit_side", int'(hit_side), e_side);
            chk("hit_top", int'(hit_top), e_top);
            chk("hit_bottom", int'(hit_bottom), e_bot);
            chk("first_idx", int'(first_idx), e_first);
            chk("hit_count", int'(hit_count), e_cnt);
        end
    end

    task automatic wr(input int i, input int e, input int x, input int y, input int l);
        @(negedge clk);
        plat_we = 1'b1; plat_idx = IW'(i); plat_en = e[0];
        plat_x = CW'(x); plat_y = CW'(y); plat_len = CW'(l);
        @(negedge clk);
        plat_we = 1'b0;
    endtask

    task automatic scan(input int x, input int y, input int w, input int h,
                        input bit noise, input bit poke, output int cyc);
        @(negedge clk);
        start = 1'b1; obj_x = CW'(x); obj_y = CW'(y); obj_w = CW'(w); obj_h = CW'(h);
        @(negedge clk);
        start = 1'b0; cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            plat_we = 1'b0; start = 1'b0;
            if (poke && cyc == 6) chk("t5_busy_wr_err", int'(wr_err), 1);
            if (done) break;
            if (poke && cyc == 5) begin
                start = 1'b1; plat_we = 1'b1; plat_idx = '0; plat_en = 1'b1;
                plat_x = '0; plat_y = '0; plat_len = '0;
            end else if (noise) begin
                start = ($urandom_range(0, 5) == 0);
                plat_we = ($urandom_range(0, 5) == 0);
                plat_idx = IW'($urandom_range(0, 21));
                plat_en = 1'(($urandom_range(0, 1)));
                plat_x = CW'($urandom_range(0, 900)); plat_y = CW'($urandom_range(0, 760));
                plat_len = CW'($urandom_range(0, 300));
                obj_x = CW'($urandom_range(0, 2047));
            end
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    function automatic int lim11(input int v);
        return v < 0 ? 0 : v > 2047 ? 2047 : v;
    endfunction

    initial begin
        int cyc, nd, j, w, h, x, y, mode;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wr(0, 1, 100, 500, 200);
        scan(150, 440, 40, 60, 0, 0, cyc);
        chk("t1_latency", cyc, 21);
        chk("t1_coll", int'(coll), 2);
        chk("t1_hit_top", int'(hit_top), 1);
        chk("t1_first_idx", int'(first_idx), 0);
        chk("t1_hit_count", int'(hit_count), 1);

        scan(60, 470, 40, 60, 0, 0, cyc);
        chk("t2_coll", int'(coll), 3);
        chk("t2_hit_side", int'(hit_side), 1);
        chk("t2_hit_top", int'(hit_top), 0);

        wr(5, 1, 150, 440, 50);
        scan(150, 440, 40, 60, 0, 0, cyc);
        chk("t3_hit_top", int'(hit_top), 1);
        chk("t3_hit_bottom", int'(hit_bottom), 1);
        chk("t3_coll", int'(coll), 3);
        chk("t3_first_idx", int'(first_idx), 0);
        chk("t3_hit_count", int'(hit_count), 2);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        scan(0, 900, 40, 60, 0, 0, cyc);
        chk("t4_x_clamped", int'(x_clamped), 1);
        chk("t4_y_clamped", int'(y_clamped), 707);
        chk("t4_coll", int'(coll), 0);
        chk("t4_hit_count", int'(hit_count), 0);

        wr(0, 1, 100, 500, 200);
        nd = n_done;
        scan(150, 440, 40, 60, 0, 1, cyc);
        repeat (N + 5) @(negedge clk);
        chk("t5_single_done", n_done - nd, 1);
        scan(150, 440, 40, 60, 0, 0, cyc);
        chk("t5_table_kept_coll", int'(coll), 2);
        chk("t5_table_kept_count", int'(hit_count), 1);
        wr(19, 1, 1, 1, 1);
        chk("t5_idx_err", int'(wr_err), 1);

        @(negedge clk);
        start = 1'b1; obj_x = 11'd150; obj_y = 11'd440; obj_w = 11'd40; obj_h = 11'd60;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_coll", int'(coll), 0);
        chk("t6_hit_count", int'(hit_count), 0);
        chk("t6_x_clamped", int'(x_clamped), 0);
        nd = n_done;
        @(negedge clk) rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_no_done", n_done - nd, 0);
        scan(150, 440, 40, 60, 0, 0, cyc);
        chk("t6_fresh_coll", int'(coll), 0);

        for (int i = 0; i < N; i++)
            wr(i, ($urandom_range(0, 4) != 0) ? 1 : 0, int'($urandom_range(0, 900)),
               int'($urandom_range(60, 760)), int'($urandom_range(0, 300)));
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0)
                wr(int'($urandom_range(0, 21)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 900)), int'($urandom_range(60, 760)),
                   int'($urandom_range(0, 300)));
            j = int'($urandom_range(0, N - 1));
            w = int'($urandom_range(1, 120));
            h = int'($urandom_range(1, 120));
            mode = int'($urandom_range(0, 4));
            x = m_x[j] + int'($urandom_range(0, m_len[j])) - w / 2;
            y = m_y[j] - h;
            if (mode == 1) y = m_y[j];
            if (mode == 2) begin x = m_x[j] - w; y = m_y[j] - int'($urandom_range(0, h)); end
            if (mode == 3) begin x = m_x[j] + m_len[j]; y = m_y[j] - int'($urandom_range(0, h)); end
            if (mode == 4) begin
                x = int'($urandom_range(0, 1100)); y = int'($urandom_range(0, 900));
                if ($urandom_range(0, 3) == 0) w = int'($urandom_range(1000, 1100));
                if ($urandom_range(0, 3) == 0) h = int'($urandom_range(740, 800));
            end
            scan(lim11(x), lim11(y), w, h, $urandom_range(0, 1) == 1, 0, cyc);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
